// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end that checks a request, drives the memory for one cycle and returns the result
module mem_access_unit #(
  parameter logic [31:0] pWords      = 32'd44,
  parameter logic        pCheckAlign = 1'b1
) (
  input  logic        iwClk,
  input  logic        iwnRst,
  input  logic        iwReqValid,
  output logic        owReqReady,
  input  logic        iwReqWrite,
  input  logic [2:0]  iwReqOp,
  input  logic [31:0] iwReqAddr,
  input  logic [31:0] iwReqData,
  output logic        owRespValid,
  input  logic        iwRespReady,
  output logic [31:0] orRespData,
  output logic        orRespErr,
  output logic [31:0] owMemReadAddr,
  output logic [31:0] owMemWriteAddr,
  output logic [31:0] owMemWriteData,
  output logic [3:0]  owMemWstrb,
  input  logic [31:0] iwMemReadData
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [32:0] mem_bytes = {1'b0, pWords} * 33'd4;
  state_t state, next_state;
  logic        wr;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] data;
  logic [32:0] size;
  logic        bad_op, misaligned, out_of_range, req_err;
  logic [31:0] load_ext;
  // Request legality: opcode, alignment and range; the end address uses 33 bits so it cannot wrap
  always_comb begin
    size         = iwReqOp[1] ? 33'd4 : iwReqOp[0] ? 33'd2 : 33'd1;
    bad_op       = iwReqWrite ? (iwReqOp > 3'd2) : (iwReqOp[1:0] == 2'b11 || iwReqOp == 3'b110);
    misaligned   = pCheckAlign && ((iwReqOp[1:0] == 2'b01 && iwReqAddr[0]) ||
                                   (iwReqOp[1:0] == 2'b10 && iwReqAddr[1:0] != 2'b00));
    out_of_range = ({1'b0, iwReqAddr} + size) > mem_bytes;
    req_err      = bad_op || misaligned || out_of_range;
  end
  // Sign/zero extension of the memory word; op[2] marks the unsigned variants
  always_comb begin
    load_ext = op[1] ? iwMemReadData
             : op[0] ? {{16{~op[2] & iwMemReadData[15]}}, iwMemReadData[15:0]}
             :         {{24{~op[2] & iwMemReadData[7]}},  iwMemReadData[7:0]};
  end
  // State register
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) state <= IDLE;
    else         state <= next_state;
  end
  // Next state: errors skip the memory cycle, responses wait for the consumer
  always_comb begin
    next_state = state;
    if (state == IDLE && iwReqValid) next_state = req_err ? RESP : ACCESS;
    else if (state == ACCESS)        next_state = RESP;
    else if (state == RESP && iwRespReady) next_state = IDLE;
  end
  // Request latch and response capture
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      wr         <= 1'b0;
      op         <= 3'd0;
      addr       <= 32'd0;
      data       <= 32'd0;
      orRespData <= 32'd0;
      orRespErr  <= 1'b0;
    end else if (state == IDLE && iwReqValid) begin
      wr         <= iwReqWrite;
      op         <= iwReqOp;
      addr       <= iwReqAddr;
      data       <= iwReqData;
      orRespData <= 32'd0;
      orRespErr  <= req_err;
    end else if (state == ACCESS) begin
      orRespData <= wr ? 32'd0 : load_ext;
    end
  end
  assign owReqReady     = (state == IDLE);
  assign owRespValid    = (state == RESP);
  assign owMemReadAddr  = addr;
  assign owMemWriteAddr = addr;
  assign owMemWriteData = data;
  // Strobes depend only on state, so an async reset removes them before the memory's falling edge
  assign owMemWstrb = (state == ACCESS && wr) ? (op[1] ? 4'hF : op[0] ? 4'h3 : 4'h1) : 4'h0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for mem_access_unit with a falling-edge byte memory model
module tb_mem_access_unit;
  logic        iwClk = 1'b0;
  logic        iwnRst = 1'b0;
  logic        iwReqValid = 1'b0;
  logic        owReqReady;
  logic        iwReqWrite = 1'b0;
  logic [2:0]  iwReqOp = 3'd0;
  logic [31:0] iwReqAddr = 32'd0;
  logic [31:0] iwReqData = 32'd0;
  logic        owRespValid;
  logic        iwRespReady = 1'b1;
  logic [31:0] orRespData;
  logic        orRespErr;
  logic [31:0] owMemReadAddr, owMemWriteAddr, owMemWriteData;
  logic [3:0]  owMemWstrb;
  logic [31:0] iwMemReadData = 32'd0;
  int checks = 0;
  int passed = 0;
  logic [32:0] exp_q[$];
  logic [7:0]  mem [0:175];
  logic        loaded = 1'b0;

  mem_access_unit dut (
    .iwClk(iwClk), .iwnRst(iwnRst), .iwReqValid(iwReqValid), .owReqReady(owReqReady),
    .iwReqWrite(iwReqWrite), .iwReqOp(iwReqOp), .iwReqAddr(iwReqAddr), .iwReqData(iwReqData),
    .owRespValid(owRespValid), .iwRespReady(iwRespReady), .orRespData(orRespData),
    .orRespErr(orRespErr), .owMemReadAddr(owMemReadAddr), .owMemWriteAddr(owMemWriteAddr),
    .owMemWriteData(owMemWriteData), .owMemWstrb(owMemWstrb), .iwMemReadData(iwMemReadData)
  );

  always #5 iwClk = ~iwClk;

  // Byte memory: preloads once, then writes strobed lanes and samples reads on each falling edge
  always @(negedge iwClk) begin
    if (!loaded) begin
      for (int i = 0; i < 176; i++) mem[i] <= 8'h00;
      mem[16] <= 8'hF1; mem[17] <= 8'hF0; mem[18] <= 8'h81; mem[19] <= 8'h80;
      mem[32] <= 8'h11; mem[33] <= 8'h22; mem[34] <= 8'h33; mem[35] <= 8'h44;
      mem[40] <= 8'h55; mem[41] <= 8'h66; mem[42] <= 8'h77; mem[43] <= 8'h88;
      mem[172] <= 8'hA1; mem[173] <= 8'hB2; mem[174] <= 8'hC3; mem[175] <= 8'hD4;
      loaded <= 1'b1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        longint unsigned wi, ri;
        wi = longint'(owMemWriteAddr) + k;
        ri = longint'(owMemReadAddr) + k;
        if (owMemWstrb[k] && wi < 176) mem[wi] <= owMemWriteData[8*k +: 8];
        iwMemReadData[8*k +: 8] <= (ri < 176) ? mem[ri] : 8'h00;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares every response at the falling edge before the handshake edge
  always @(negedge iwClk) begin
    if (iwnRst && owRespValid && iwRespReady) begin
      if (exp_q.size() == 0) chk("unexpected_resp", {31'd0, owRespValid}, 32'd0);
      else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_err", {31'd0, orRespErr}, {31'd0, e[32]});
        chk("resp_data", orRespData, e[31:0]);
      end
    end
  end

  // One full transaction with latency, strobe and address checks; called at posedge+1 in IDLE
  task automatic req(input logic w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                     input logic err, input logic [31:0] exp, input logic [3:0] strb);
    chk("req_ready", {31'd0, owReqReady}, 32'd1);
    iwReqValid = 1'b1; iwReqWrite = w; iwReqOp = o; iwReqAddr = a; iwReqData = d;
    exp_q.push_back({err, exp});
    @(posedge iwClk); #1;
    iwReqValid = 1'b0;
    if (err) begin
      chk("err_valid_n1", {31'd0, owRespValid}, 32'd1);
      chk("err_wstrb", {28'd0, owMemWstrb}, 32'd0);
    end else begin
      chk("acc_valid_n1", {31'd0, owRespValid}, 32'd0);
      chk("acc_ready", {31'd0, owReqReady}, 32'd0);
      chk("acc_wstrb", {28'd0, owMemWstrb}, {28'd0, strb});
      chk("acc_waddr", owMemWriteAddr, a);
      chk("acc_raddr", owMemReadAddr, a);
      chk("acc_wdata", owMemWriteData, d);
      @(posedge iwClk); #1;
      chk("valid_n2", {31'd0, owRespValid}, 32'd1);
      chk("resp_wstrb", {28'd0, owMemWstrb}, 32'd0);
    end
    @(posedge iwClk); #1;
    chk("back_idle", {31'd0, owRespValid}, 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_req_ready", {31'd0, owReqReady}, 32'd1);
    chk("rst_resp_valid", {31'd0, owRespValid}, 32'd0);
    chk("rst_resp_data", orRespData, 32'd0);
    chk("rst_resp_err", {31'd0, orRespErr}, 32'd0);
    chk("rst_wstrb", {28'd0, owMemWstrb}, 32'd0);
    chk("rst_raddr", owMemReadAddr, 32'd0);
    chk("rst_wdata", owMemWriteData, 32'd0);
    #11 iwnRst = 1'b1;
    @(posedge iwClk); #1;
    req(0, 3'b010, 32'h10, 32'd0, 0, 32'h8081F0F1, 4'h0);
    req(0, 3'b000, 32'h10, 32'd0, 0, 32'hFFFFFFF1, 4'h0);
    req(0, 3'b100, 32'h12, 32'd0, 0, 32'h00000081, 4'h0);
    req(0, 3'b001, 32'h12, 32'd0, 0, 32'hFFFF8081, 4'h0);
    req(0, 3'b101, 32'h10, 32'd0, 0, 32'h0000F0F1, 4'h0);
    req(1, 3'b001, 32'h20, 32'hDEADBEEF, 0, 32'd0, 4'h3);
    req(0, 3'b010, 32'h20, 32'd0, 0, 32'h4433BEEF, 4'h0);
    req(1, 3'b010, 32'h24, 32'h12345678, 0, 32'd0, 4'hF);
    req(0, 3'b000, 32'h27, 32'd0, 0, 32'h00000012, 4'h0);
    req(0, 3'b010, 32'h22, 32'd0, 1, 32'd0, 4'h0);
    req(0, 3'b000, 32'd176, 32'd0, 1, 32'd0, 4'h0);
    req(1, 3'b010, 32'hFFFFFFFC, 32'h1, 1, 32'd0, 4'h0);
    req(0, 3'b011, 32'h10, 32'd0, 1, 32'd0, 4'h0);
    req(0, 3'b010, 32'd172, 32'd0, 0, 32'hD4C3B2A1, 4'h0);
    req(0, 3'b100, 32'd175, 32'd0, 0, 32'h000000D4, 4'h0);
    // Back-pressure: response held while RespReady is low, new request ignored
    iwRespReady = 1'b0;
    iwReqValid = 1'b1; iwReqWrite = 1'b0; iwReqOp = 3'b010; iwReqAddr = 32'h10;
    exp_q.push_back({1'b0, 32'h8081F0F1});
    @(posedge iwClk); #1;
    iwReqValid = 1'b0;
    @(posedge iwClk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", {31'd0, owRespValid}, 32'd1);
      chk("hold_data", orRespData, 32'h8081F0F1);
      chk("hold_err", {31'd0, orRespErr}, 32'd0);
      chk("hold_req_ready", {31'd0, owReqReady}, 32'd0);
      if (i == 0) begin
        iwReqValid = 1'b1; iwReqOp = 3'b000; iwReqAddr = 32'h10;
      end
      @(posedge iwClk); #1;
    end
    iwReqValid = 1'b0;
    iwRespReady = 1'b1;
    @(posedge iwClk); #1;
    chk("release_valid", {31'd0, owRespValid}, 32'd0);
    chk("release_ready", {31'd0, owReqReady}, 32'd1);
    // Reset in the middle of a store access must suppress the write
    iwReqValid = 1'b1; iwReqWrite = 1'b1; iwReqOp = 3'b010; iwReqAddr = 32'h28; iwReqData = 32'hAABBCCDD;
    @(posedge iwClk); #1;
    iwReqValid = 1'b0;
    chk("pre_rst_wstrb", {28'd0, owMemWstrb}, 32'hF);
    #1 iwnRst = 1'b0;
    #1;
    chk("mid_rst_wstrb", {28'd0, owMemWstrb}, 32'd0);
    chk("mid_rst_ready", {31'd0, owReqReady}, 32'd1);
    chk("mid_rst_valid", {31'd0, owRespValid}, 32'd0);
    chk("mid_rst_waddr", owMemWriteAddr, 32'd0);
    @(posedge iwClk); #1;
    iwnRst = 1'b1;
    @(posedge iwClk); #1;
    req(0, 3'b010, 32'h28, 32'd0, 0, 32'h88776655, 4'h0);
    repeat (3) @(posedge iwClk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end directly upstream of the byte-addressed simple memory; the core's execute stage issues one request at a time through it.
- Accepts a valid/ready request (load or store, RISC-V funct3-style width code) and checks alignment, range and opcode.
- Drives the memory's read/write address, write data and byte strobes for exactly one cycle, then returns a sign/zero-extended load result or store acknowledge on a valid/ready response channel.

Parameters:
pWords, 32'd44, memory size in 32-bit words; valid byte addresses are 0 .. pWords*4-1.
pCheckAlign, 1'b1, 1 = misaligned half/word accesses return an error; 0 = alignment not checked, range check only.

Ports:
iwClk  input  1  clock; the memory writes and samples reads on the falling edge, this block is posedge.
iwnRst  input  1  reset, asynchronous, active-low.
iwReqValid  input  1  request valid.
owReqReady  output  1  request ready.
iwReqWrite  input  1  1 = store, 0 = load.
iwReqOp  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; stores accept only 000/001/010.
iwReqAddr  input  32  byte address.
iwReqData  input  32  store data, right-aligned.
owRespValid  output  1  response valid.
iwRespReady  input  1  response accepted.
orRespData  output  32  extended load data; 0 for stores and errors.
orRespErr  output  1  1 = request rejected, no memory access made.
owMemReadAddr  output  32  to memory read address.
owMemWriteAddr  output  32  to memory write address.
owMemWriteData  output  32  to memory write data.
owMemWstrb  output  4  to memory byte strobes.
iwMemReadData  input  32  from memory read data; byte k = mem[addr+k].

Behaviour:
- State machine: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values:
  - owReqReady = 1, owRespValid = 0.
  - orRespData = 0, orRespErr = 0.
  - Latched address and data = 0, so both memory addresses and write data are 0.
  - owMemWstrb = 0.
- IDLE:
  - owReqReady = 1.
  - On iwReqValid at a posedge, latch write, op, addr and data, and evaluate the error.
  - Error → RESP with err = 1, data = 0.
  - No error → ACCESS.
- Error conditions (any of):
  - Invalid op (load 011/110/111; store other than 000–010).
  - pCheckAlign set and addr[0] != 0 for a half access, or addr[1:0] != 0 for a word access.
  - addr + size > pWords*4, with size 1/2/4. Compute in 33 bits so that 0xFFFFFFFF does not wrap.
- ACCESS (exactly one cycle):
  - owMemReadAddr = owMemWriteAddr = latched addr.
  - owMemWriteData = latched data, unshifted (the memory lanes are address-relative).
  - owMemWstrb: store B = 0001, H = 0011, W = 1111; loads = 0000.
  - The memory acts at the falling edge inside this cycle.
  - At the next posedge, capture iwMemReadData and go to RESP:
    - B: sign-extend bits [7:0].
    - BU: zero-extend bits [7:0].
    - H: sign-extend bits [15:0].
    - HU: zero-extend bits [15:0].
    - W: pass all 32 bits.
    - Stores: 0.
- RESP:
  - owRespValid = 1.
  - orRespData and orRespErr held stable until iwRespReady is seen at a posedge, then IDLE.
  - owReqReady = 0 in ACCESS and RESP; no overlap or pipelining.
- owMemWstrb is nonzero only in ACCESS with a store, and comes straight from state and latched op (no glitch into other states).
- Outside ACCESS, the memory addresses and write data hold their last latched values.
- Latency:
  - Legal request accepted at edge N → RespValid from edge N+2.
  - Error request accepted at edge N → RespValid from edge N+1.
  - Minimum throughput is one request per 3 cycles with RespReady tied high.
- Asynchronous reset in any state:
  - Immediate return to IDLE with all outputs at reset values.
  - owMemWstrb drops to 0 without waiting for a clock edge, so a reset during store ACCESS must not complete a partial write at the following negedge.
- RespValid is not withdrawn while RespReady is low; the request side is ignored until the response is taken.

Test Plan:
- Preload mem[0x10..0x13] = F1,F0,81,80, then load the following (each resp err = 0, RespValid two edges after accept):
  - LW 0x10 → 0x8081F0F1.
  - LB 0x10 → 0xFFFFFFF1.
  - LBU 0x12 → 0x00000081.
  - LH 0x12 → 0xFFFF8081.
  - LHU 0x10 → 0x0000F0F1.
- SH 0x20 data 0xDEADBEEF → owMemWstrb = 0011 for exactly one cycle, write addr 0x20. Then LW 0x20 → 0x????BEEF, with bytes 0x22/0x23 unchanged from preload.
- SW 0x24 data 0x12345678 → Wstrb 1111, resp data 0, err 0. Then LB 0x27 → 0x00000012.
- Errors with default pWords (range limit 176), each giving err = 1 and data 0 one edge after accept, Wstrb never nonzero:
  - LW 0x22 (misaligned).
  - LB 176.
  - SW 0xFFFFFFFC.
  - Load op 011.
- LW 172 (last word) → legal, returns the last memory word.
- Hold iwRespReady low 4 cycles after RespValid → RespValid, data and err stable, owReqReady = 0, a new request ignored. Raise RespReady → IDLE next edge.
- Assert iwnRst during store ACCESS → Wstrb 0 immediately, target bytes unchanged, ReqReady = 1. Next LW returns the old value.
